// File: rtl/fifo_level_ctrl_if.sv
// Control/status bundle between a FIFO level controller and its user.
// The slave modport is the controller side; master drives requests and thresholds.
interface fifo_level_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int LVL_W  = ADDR_W + 1
);
  logic              clr;
  logic              w_en;
  logic              r_en;
  logic [LVL_W-1:0]  ae_thresh;
  logic [LVL_W-1:0]  af_thresh;
  logic              err_clr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic              w_ack;
  logic              r_ack;
  logic [LVL_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, w_en, r_en, ae_thresh, af_thresh, err_clr,
    input  w_addr, r_addr, w_ack, r_ack, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  clr, w_en, r_en, ae_thresh, af_thresh, err_clr,
    output w_addr, r_addr, w_ack, r_ack, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_level_ctrl.sv
// FIFO pointer/occupancy controller: comb accept, flags registered from next count (zero lag).
// Writes refused when full, reads refused when empty; refusals latch sticky errors.
module fifo_level_ctrl #(
  parameter int ADDR_W = 3,
  parameter int LVL_W  = ADDR_W + 1
) (
  input logic             clk,
  input logic             n_rst,
  fifo_level_ctrl_if.slave bus
);
  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  ONE_L   = LVL_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_raddr;
  logic [LVL_W-1:0]  r_count;
  logic              r_empty;
  logic              r_full;
  logic              r_aempty;
  logic              r_afull;
  logic              r_ovf;
  logic              r_udf;

  logic              w_wack;
  logic              w_rack;
  logic [LVL_W-1:0]  w_count_nxt;

  // Accept decisions look only at registered full/empty so there is no comb path from the count adder.
  always_comb begin
    w_wack      = bus.w_en & ~r_full  & ~bus.clr;
    w_rack      = bus.r_en & ~r_empty & ~bus.clr;
    w_count_nxt = r_count;
    if (bus.clr)
      w_count_nxt = '0;
    else if (w_wack & ~w_rack)
      w_count_nxt = r_count + ONE_L;
    else if (w_rack & ~w_wack)
      w_count_nxt = r_count - ONE_L;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_waddr  <= '0;
      r_raddr  <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
    end else begin
      if (bus.clr) begin
        r_waddr <= '0;
        r_raddr <= '0;
      end else begin
        if (w_wack) r_waddr <= r_waddr + ONE_A;
        if (w_rack) r_raddr <= r_raddr + ONE_A;
      end
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == DEPTH_L);
      r_aempty <= (w_count_nxt <= bus.ae_thresh);
      r_afull  <= (w_count_nxt >= bus.af_thresh);
    end
  end

  // Set has priority over err_clr so an error in the clearing cycle is never lost.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (bus.w_en & r_full)  | (r_ovf & ~bus.err_clr);
      r_udf <= (bus.r_en & r_empty) | (r_udf & ~bus.err_clr);
    end
  end

  assign bus.w_addr       = r_waddr;
  assign bus.r_addr       = r_raddr;
  assign bus.w_ack        = w_wack;
  assign bus.r_ack        = w_rack;
  assign bus.count        = r_count;
  assign bus.empty        = r_empty;
  assign bus.full         = r_full;
  assign bus.almost_empty = r_aempty;
  assign bus.almost_full  = r_afull;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;
endmodule

// File: doc/fifo_level_ctrl.md
FIFO_LEVEL_CTRL -- requirements
Module: fifo_level_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, pointer width; DEPTH = 2**ADDR_W entries.
REQ-002 SHALL have parameter LVL_W, default ADDR_W+1, occupancy and threshold width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- n_rst  in  1  async active-low reset.
- clr  in  1  sync flush of pointers and level.
- w_en  in  1  write request.
- r_en  in  1  read request.
- ae_thresh  in  LVL_W  almost-empty threshold.
- af_thresh  in  LVL_W  almost-full threshold.
- err_clr  in  1  sync clear of sticky errors.
- w_addr  out  ADDR_W  storage write address.
- r_addr  out  ADDR_W  storage read address.
- w_ack  out  1  write accepted this cycle (comb).
- r_ack  out  1  read accepted this cycle (comb).
- count  out  LVL_W  occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= ae_thresh.
- almost_full  out  1  count >= af_thresh.
- overflow  out  1  sticky, write refused.
- underflow  out  1  sticky, read refused.

Function
REQ-005 SHALL assert w_ack = w_en & ~full and r_ack = r_en & ~empty, using registered full/empty only.
REQ-006 SHALL advance w_addr by 1 mod DEPTH on each w_ack edge; r_addr likewise on r_ack; both wrap DEPTH-1 -> 0.
REQ-007 SHALL update count: +1 on w_ack only, -1 on r_ack only, unchanged on both or neither.
REQ-008 Simultaneous w_en and r_en when full: read accepted, write refused; count goes DEPTH -> DEPTH-1.
REQ-009 Simultaneous w_en and r_en when empty: write accepted, read refused; count goes 0 -> 1.
REQ-010 SHALL register empty, full, almost_empty, almost_full, computed from next-cycle count, so they change on the same edge as count; zero cycle lag.
REQ-011 SHALL compare thresholds unsigned at LVL_W width; the value sampled at an edge governs flags from that edge.
REQ-012 ae_thresh >= DEPTH SHALL hold almost_empty at 1; af_thresh == 0 SHALL hold almost_full at 1; almost_empty and almost_full may be high together.
REQ-013 SHALL set overflow on any edge with w_en & full; SHALL set underflow on any edge with r_en & empty; both hold until err_clr or reset.
REQ-014 err_clr coinciding with a new error event SHALL leave the flag set (set wins).
REQ-015 clr SHALL, on the next edge, zero w_addr, r_addr and count and set empty; it SHALL override w_en/r_en that cycle, force w_ack/r_ack to 0, and not alter overflow/underflow.
REQ-016 SHALL keep count equal to (w_addr - r_addr) mod DEPTH, or DEPTH when full, at all times.

Reset
REQ-017 n_rst low SHALL immediately force w_addr=0, r_addr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, regardless of clk.
REQ-018 Reset asserted mid-operation SHALL discard all occupancy; the first edge after deassertion SHALL behave as from empty.

Verification (ADDR_W=3, ae_thresh=2, af_thresh=6 unless stated)
REQ-019 Reset then 8 writes -> count 1..8; almost_empty drops on count=3; almost_full rises on count=6; full on 8th edge; w_addr wraps to 0.
REQ-020 Full, w_en=1 and r_en=1 for one edge -> r_ack=1, w_ack=0, count=7, overflow=1, full=0.
REQ-021 Empty, r_en=1 -> r_ack=0, count=0, underflow=1; err_clr=1 next edge -> underflow=0.
REQ-022 count=5, w_en=r_en=1 for 10 edges -> count holds 5, both pointers wrap, flags unchanged.
REQ-023 count=5, change af_thresh to 5 -> almost_full=1 on the next edge; clr=1 -> count=0, empty=1, almost_empty=1, sticky errors retained.
REQ-024 count=4, n_rst pulsed low between edges -> all outputs at reset values before the next edge.
